pipe_run_ctrl: RTL and testbench

Synthesizable run controller for the forwarding pipeline: sequences the core's reset, runs a configurable number of bounded execution windows, and ends each run early when the program counter parks in a self-loop. It sits between the board/bench reset and the processor's `rst_ni`. It replaces hand-timed reset pulses with a parametrised, cycle-exact sequencer usable both on FPGA and in simulation.

---
 rtl/pipe_run_pkg.sv | 20 ++
 rtl/pc_stall_detect.sv | 45 ++++
 rtl/pipe_run_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_run_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_run_pkg.sv
// Shared state encoding and counter-width helpers for the pipeline run controller.
package pipe_run_pkg;

    // Controller states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Bits needed for a counter that must hold values 0..max_val (minimum one bit).
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // Bits for a run index over n runs; one spare bit keeps the index unambiguous.
    function automatic int idx_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/pc_stall_detect.sv
// Watches the core fetch PC during a run and flags a halt when it parks
// on the same value for STALL_LIMIT consecutive run cycles.
module pc_stall_detect
    import pipe_run_pkg::*;
#(
    parameter int PC_W        = 32,
    parameter int STALL_LIMIT = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            run_i,
    input  logic [PC_W-1:0] pc_i,
    output logic            halt_o
);

    localparam int STL_W = cnt_w(STALL_LIMIT - 1);

    logic [PC_W-1:0]  pc_q;
    logic             pc_vld_q;
    logic [STL_W-1:0] stall_cnt_q;
    logic             pc_match;

    // No comparison on the first run cycle: pc_vld_q is only set once a PC has been captured.
    assign pc_match = pc_vld_q && (pc_i == pc_q);

    // Halt on the match that brings the stall count to STALL_LIMIT-1.
    assign halt_o = run_i && pc_match && (stall_cnt_q == STL_W'(STALL_LIMIT - 2));

    // Capture PC and count consecutive matches while running; forget everything outside RUN.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q        <= '0;
            pc_vld_q    <= 1'b0;
            stall_cnt_q <= '0;
        end else if (run_i) begin
            pc_q        <= pc_i;
            pc_vld_q    <= 1'b1;
            stall_cnt_q <= pc_match ? (stall_cnt_q + STL_W'(1)) : '0;
        end else begin
            pc_vld_q    <= 1'b0;
            stall_cnt_q <= '0;
        end
    end

endmodule

// File: rtl/pipe_run_ctrl.sv
// Run controller: holds the core in reset, releases it for bounded runs,
// ends a run on cycle budget or PC self-loop, and repeats NUM_RUNS times.
//
//   state | meaning
//   IDLE  | waiting for start_i, core held in reset
//   HOLD  | core held in reset for RESET_HOLD cycles before a run
//   RUN   | core released, cycle budget and PC stall tracked
//   DONE  | all runs finished, core held in reset until restart_i
module pipe_run_ctrl
    import pipe_run_pkg::*;
#(
    parameter int RESET_HOLD  = 3,
    parameter int RUN_CYCLES  = 2500,
    parameter int NUM_RUNS    = 2,
    parameter int STALL_LIMIT = 16,
    parameter int PC_W        = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            start_i,
    input  logic                            restart_i,
    input  logic [PC_W-1:0]                 pc_i,
    output logic                            core_rst_no,
    output logic                            running_o,
    output logic [idx_w(NUM_RUNS)-1:0]      run_idx_o,
    output logic [cnt_w(RUN_CYCLES)-1:0]    cycle_cnt_o,
    output logic                            halt_o,
    output logic                            timeout_o,
    output logic                            done_o
);

    localparam int IDX_W = idx_w(NUM_RUNS);
    localparam int CYC_W = cnt_w(RUN_CYCLES);
    localparam int HLD_W = cnt_w(RESET_HOLD - 1);

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [HLD_W-1:0] hold_cnt_q;
    logic             halt_hit;
    logic             tmo_hit;
    logic             run_end;
    logic             last_run;
    logic             hold_enter;
    logic             start_go;
    logic             restart_go;

    pc_stall_detect #(
        .PC_W        (PC_W),
        .STALL_LIMIT (STALL_LIMIT)
    ) u_stall (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .run_i  (state_q == ST_RUN),
        .pc_i   (pc_i),
        .halt_o (halt_hit)
    );

    assign tmo_hit    = (cycle_cnt_o == CYC_W'(RUN_CYCLES - 1));
    assign last_run   = (run_idx_o == IDX_W'(NUM_RUNS - 1));
    assign start_go   = start_i && (state_q == ST_IDLE);
    assign restart_go = restart_i && (state_q != ST_IDLE);
    assign running_o  = (state_q == ST_RUN);

    // Restart re-enters HOLD even from HOLD itself, so the hold timer reloads.
    assign hold_enter = (state_d == ST_HOLD) && ((state_q != ST_HOLD) || restart_i);

    // Next-state logic; restart outranks any run-end event in the same cycle.
    always_comb begin
        state_d = state_q;
        run_end = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (restart_i)               state_d = ST_HOLD;
                else if (hold_cnt_q == '0)   state_d = ST_RUN;
            end
            ST_RUN: begin
                if (restart_i) begin
                    state_d = ST_HOLD;
                end else if (halt_hit || tmo_hit) begin
                    run_end = 1'b1;
                    state_d = last_run ? ST_DONE : ST_HOLD;
                end
            end
            ST_DONE: begin
                if (restart_i) state_d = ST_HOLD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register and registered core reset / done level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            core_rst_no <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            state_q     <= state_d;
            core_rst_no <= (state_d == ST_RUN);
            done_o      <= (state_d == ST_DONE);
        end
    end

    // Reset-hold down-counter, loaded on every HOLD entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_cnt_q <= '0;
        end else if (hold_enter) begin
            hold_cnt_q <= HLD_W'(RESET_HOLD - 1);
        end else if ((state_q == ST_HOLD) && (hold_cnt_q != '0)) begin
            hold_cnt_q <= hold_cnt_q - HLD_W'(1);
        end
    end

    // Run index: zeroed on start/restart, advanced when a non-final run ends.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_idx_o <= '0;
        end else if (start_go || restart_go) begin
            run_idx_o <= '0;
        end else if (run_end && !last_run) begin
            run_idx_o <= run_idx_o + IDX_W'(1);
        end
    end

    // Core-active cycle counter; holds its final value once the run ends.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cycle_cnt_o <= '0;
        end else if (hold_enter) begin
            cycle_cnt_o <= '0;
        end else if ((state_q == ST_RUN) && !run_end) begin
            cycle_cnt_o <= cycle_cnt_o + CYC_W'(1);
        end
    end

    // End-cause flags: written at run end (halt wins), cleared on any other HOLD entry.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            halt_o    <= 1'b0;
            timeout_o <= 1'b0;
        end else if (run_end) begin
            halt_o    <= halt_hit;
            timeout_o <= !halt_hit;
        end else if (hold_enter) begin
            halt_o    <= 1'b0;
            timeout_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pipe_run_ctrl.sv
// Directed bench for pipe_run_ctrl with RESET_HOLD=3, RUN_CYCLES=10, NUM_RUNS=2, STALL_LIMIT=4.
module tb_pipe_run_ctrl;

    localparam int RESET_HOLD  = 3;
    localparam int RUN_CYCLES  = 10;
    localparam int NUM_RUNS    = 2;
    localparam int STALL_LIMIT = 4;
    localparam int PC_W        = 32;

    logic        clk_i     = 1'b0;
    logic        rst_ni    = 1'b1;
    logic        start_i   = 1'b0;
    logic        restart_i = 1'b0;
    logic [31:0] pc_i      = 32'h0;
    logic        core_rst_no;
    logic        running_o;
    logic [1:0]  run_idx_o;
    logic [3:0]  cycle_cnt_o;
    logic        halt_o;
    logic        timeout_o;
    logic        done_o;

    int checks   = 0;
    int failures = 0;

    // One record per run pattern: PC change mask per RUN cycle and the expected run outcome.
    typedef struct {
        logic [9:0]  mask;
        logic [31:0] pc0;
        int          len;
        logic        halt;
        logic        tmo;
    } vec_t;

    vec_t vecs [7];

    pipe_run_ctrl #(
        .RESET_HOLD  (RESET_HOLD),
        .RUN_CYCLES  (RUN_CYCLES),
        .NUM_RUNS    (NUM_RUNS),
        .STALL_LIMIT (STALL_LIMIT),
        .PC_W        (PC_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .restart_i   (restart_i),
        .pc_i        (pc_i),
        .core_rst_no (core_rst_no),
        .running_o   (running_o),
        .run_idx_o   (run_idx_o),
        .cycle_cnt_o (cycle_cnt_o),
        .halt_o      (halt_o),
        .timeout_o   (timeout_o),
        .done_o      (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Pulse start_i or restart_i for one cycle; returns in the cycle after the sampling edge.
    task automatic trigger(input bit use_restart);
        if (use_restart) restart_i = 1'b1;
        else             start_i   = 1'b1;
        step();
        restart_i = 1'b0;
        start_i   = 1'b0;
    endtask

    // Called in the first HOLD cycle; measures the hold, drives the PC pattern, checks the outcome.
    task automatic do_run(input logic [9:0] mask, input logic [31:0] pc0, input int exp_len,
                          input logic exp_halt, input logic exp_tmo, input int run_no,
                          input logic exp_done);
        int n;
        int k;
        int last_cnt;
        n = 0;
        k = 0;
        last_cnt = -1;
        while (core_rst_no === 1'b0 && n < 20) begin
            n++;
            step();
        end
        chk("hold_len", n, RESET_HOLD);
        chk("run_idx_in_run", 32'(run_idx_o), run_no);
        chk("cnt_first_run_cycle", 32'(cycle_cnt_o), 0);
        while (running_o === 1'b1 && k < 20) begin
            if (k == 0)                    pc_i = pc0;
            else if (k < 10 && mask[k])    pc_i = pc_i + 32'd4;
            last_cnt = int'(cycle_cnt_o);
            k++;
            step();
        end
        chk("run_len", k, exp_len);
        chk("cnt_last_run_cycle", last_cnt, exp_len - 1);
        chk("halt_after_run", 32'(halt_o), 32'(exp_halt));
        chk("timeout_after_run", 32'(timeout_o), 32'(exp_tmo));
        chk("run_idx_after_run", 32'(run_idx_o), (run_no < NUM_RUNS - 1) ? run_no + 1 : run_no);
        chk("core_rst_after_run", 32'(core_rst_no), 0);
        chk("done_after_run", 32'(done_o), 32'(exp_done));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int k;

        vecs[0] = '{10'h3FF, 32'h0000_0000, 10, 1'b0, 1'b1};  // PC +4 every cycle
        vecs[1] = '{10'h000, 32'h0000_0010,  4, 1'b1, 1'b0};  // stuck from first RUN cycle
        vecs[2] = '{10'h008, 32'h0000_0100,  7, 1'b1, 1'b0};  // 3 constant, change, 4 constant
        vecs[3] = '{10'h07F, 32'h0000_0200, 10, 1'b1, 1'b0};  // stall completes on 10th cycle
        vecs[4] = '{10'h0FF, 32'h0000_0300, 10, 1'b0, 1'b1};  // only 3 constant at the end
        vecs[5] = '{10'h249, 32'h0000_0400, 10, 1'b0, 1'b1};  // repeated 3-cycle stretches
        vecs[6] = '{10'h002, 32'h0000_0500,  5, 1'b1, 1'b0};  // 4 constant starting at cycle 2

        #2 rst_ni = 1'b0;
        #8;
        chk("rst_core_rst", 32'(core_rst_no), 0);
        chk("rst_running", 32'(running_o), 0);
        chk("rst_run_idx", 32'(run_idx_o), 0);
        chk("rst_cycle_cnt", 32'(cycle_cnt_o), 0);
        chk("rst_halt", 32'(halt_o), 0);
        chk("rst_timeout", 32'(timeout_o), 0);
        chk("rst_done", 32'(done_o), 0);
        #2 rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("idle_no_start_core_rst", 32'(core_rst_no), 0);
        chk("idle_no_start_running", 32'(running_o), 0);

        // Table: first pattern starts from IDLE, later ones restart from DONE.
        for (int r = 0; r < 7; r++) begin
            trigger(r != 0);
            chk("hold_entry_done_clear", 32'(done_o), 0);
            chk("hold_entry_halt_clear", 32'(halt_o), 0);
            chk("hold_entry_timeout_clear", 32'(timeout_o), 0);
            do_run(vecs[r].mask, vecs[r].pc0, vecs[r].len, vecs[r].halt, vecs[r].tmo, 0, 1'b0);
            do_run(vecs[r].mask, vecs[r].pc0, vecs[r].len, vecs[r].halt, vecs[r].tmo, 1, 1'b1);
        end

        // start_i in DONE is ignored.
        trigger(1'b0);
        step();
        step();
        chk("done_start_ignored_done", 32'(done_o), 1);
        chk("done_start_ignored_core_rst", 32'(core_rst_no), 0);
        chk("done_start_ignored_running", 32'(running_o), 0);
        chk("done_start_ignored_idx", 32'(run_idx_o), 1);

        // restart_i in run 1 at cycle 5, then a full sequence.
        trigger(1'b1);
        do_run(10'h3FF, 32'h0, 10, 1'b0, 1'b1, 0, 1'b0);
        n = 0;
        while (core_rst_no === 1'b0 && n < 20) begin
            n++;
            step();
        end
        chk("restart_hold_len", n, RESET_HOLD);
        k = 0;
        while (cycle_cnt_o !== 4'd5 && running_o === 1'b1 && k < 20) begin
            pc_i = pc_i + 32'd4;
            k++;
            step();
        end
        chk("restart_at_cnt5", 32'(cycle_cnt_o), 5);
        chk("restart_idx_before", 32'(run_idx_o), 1);
        restart_i = 1'b1;
        pc_i = pc_i + 32'd4;
        step();
        restart_i = 1'b0;
        chk("restart_running", 32'(running_o), 0);
        chk("restart_core_rst", 32'(core_rst_no), 0);
        chk("restart_run_idx", 32'(run_idx_o), 0);
        chk("restart_done", 32'(done_o), 0);
        chk("restart_cycle_cnt", 32'(cycle_cnt_o), 0);
        chk("restart_timeout_clear", 32'(timeout_o), 0);
        do_run(10'h3FF, 32'h0, 10, 1'b0, 1'b1, 0, 1'b0);
        do_run(10'h3FF, 32'h0, 10, 1'b0, 1'b1, 1, 1'b1);

        // Async reset in the middle of a run.
        trigger(1'b1);
        n = 0;
        while (core_rst_no === 1'b0 && n < 20) begin
            n++;
            step();
        end
        for (int i = 0; i < 3; i++) begin
            pc_i = pc_i + 32'd4;
            step();
        end
        chk("pre_async_running", 32'(running_o), 1);
        #2 rst_ni = 1'b0;
        #1;
        chk("async_rst_core_rst", 32'(core_rst_no), 0);
        chk("async_rst_running", 32'(running_o), 0);
        chk("async_rst_cycle_cnt", 32'(cycle_cnt_o), 0);
        chk("async_rst_run_idx", 32'(run_idx_o), 0);
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        for (int i = 0; i < 5; i++) step();
        chk("post_rst_idle_core_rst", 32'(core_rst_no), 0);
        chk("post_rst_idle_running", 32'(running_o), 0);
        chk("post_rst_idle_done", 32'(done_o), 0);
        trigger(1'b0);
        do_run(10'h3FF, 32'h0, 10, 1'b0, 1'b1, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
